// File: rtl/cgra_exec_sequencer_if.sv
// Handshake/status bundle between the CGRA host side and the execution sequencer.
// The sequencer uses the slave modport; the host/controller drives through master.
interface cgra_exec_sequencer_if #(
    parameter int INPUT_NODES_NUM  = 4,
    parameter int OUTPUT_NODES_NUM = 4
);
    logic                        load_configuration_i;
    logic                        start_execution_i;
    logic                        clear_cgra_config_i;
    logic                        clear_cgra_state_i;
    logic                        reset_state_machines_i;
    logic [INPUT_NODES_NUM-1:0]  in_active_i;
    logic [OUTPUT_NODES_NUM-1:0] out_active_i;
    logic                        cfg_done_i;
    logic [OUTPUT_NODES_NUM-1:0] out_done_i;
    logic                        stall_i;

    logic                        cfg_start_o;
    logic [INPUT_NODES_NUM-1:0]  in_start_o;
    logic [OUTPUT_NODES_NUM-1:0] out_start_o;
    logic                        clr_config_o;
    logic                        clr_state_o;
    logic                        done_config_o;
    logic                        done_exec_output_o;
    logic                        busy_o;
    logic [31:0]                 cycle_count_load_config_o;
    logic [31:0]                 cycle_count_execute_o;
    logic [31:0]                 cycle_count_stall_o;

    modport slave (
        input  load_configuration_i, start_execution_i, clear_cgra_config_i,
        input  clear_cgra_state_i, reset_state_machines_i, in_active_i, out_active_i,
        input  cfg_done_i, out_done_i, stall_i,
        output cfg_start_o, in_start_o, out_start_o, clr_config_o, clr_state_o,
        output done_config_o, done_exec_output_o, busy_o,
        output cycle_count_load_config_o, cycle_count_execute_o, cycle_count_stall_o
    );

    modport master (
        output load_configuration_i, start_execution_i, clear_cgra_config_i,
        output clear_cgra_state_i, reset_state_machines_i, in_active_i, out_active_i,
        output cfg_done_i, out_done_i, stall_i,
        input  cfg_start_o, in_start_o, out_start_o, clr_config_o, clr_state_o,
        input  done_config_o, done_exec_output_o, busy_o,
        input  cycle_count_load_config_o, cycle_count_execute_o, cycle_count_stall_o
    );
endinterface

// File: rtl/cgra_exec_sequencer.sv
// CGRA execution sequencer: sequences configuration load and stream execution,
// issues start/clear pulses and keeps saturating performance counters.
module cgra_exec_sequencer #(
    parameter int INPUT_NODES_NUM  = 4,
    parameter int OUTPUT_NODES_NUM = 4
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    cgra_exec_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CFG  = 2'd1,
        EXEC = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [OUTPUT_NODES_NUM-1:0] pending_q, pending_d;
    logic [OUTPUT_NODES_NUM-1:0] remaining;
    logic                        cfg_start_q, cfg_start_d;
    logic [INPUT_NODES_NUM-1:0]  in_start_q, in_start_d;
    logic [OUTPUT_NODES_NUM-1:0] out_start_q, out_start_d;
    logic                        clr_config_q, clr_state_q;
    logic                        done_cfg_q, done_cfg_d;
    logic                        done_exec_q, done_exec_d;
    logic [31:0]                 cnt_cfg_q, cnt_cfg_d;
    logic [31:0]                 cnt_exec_q, cnt_exec_d;
    logic [31:0]                 cnt_stall_q, cnt_stall_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            cfg_start_q  <= 1'b0;
            in_start_q   <= '0;
            out_start_q  <= '0;
            clr_config_q <= 1'b0;
            clr_state_q  <= 1'b0;
            done_cfg_q   <= 1'b0;
            done_exec_q  <= 1'b0;
            cnt_cfg_q    <= '0;
            cnt_exec_q   <= '0;
            cnt_stall_q  <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            cfg_start_q  <= cfg_start_d;
            in_start_q   <= in_start_d;
            out_start_q  <= out_start_d;
            clr_config_q <= bus.clear_cgra_config_i;
            clr_state_q  <= bus.clear_cgra_state_i;
            done_cfg_q   <= done_cfg_d;
            done_exec_q  <= done_exec_d;
            cnt_cfg_q    <= cnt_cfg_d;
            cnt_exec_q   <= cnt_exec_d;
            cnt_stall_q  <= cnt_stall_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        cfg_start_d = 1'b0;
        in_start_d  = '0;
        out_start_d = '0;
        done_cfg_d  = done_cfg_q;
        done_exec_d = done_exec_q;
        cnt_cfg_d   = cnt_cfg_q;
        cnt_exec_d  = cnt_exec_q;
        cnt_stall_d = cnt_stall_q;
        remaining   = pending_q & ~bus.out_done_i;

        case (state_q)
            IDLE: begin
                // An abort in IDLE must not zero the counters, so commands are gated here.
                if (!bus.reset_state_machines_i) begin
                    if (bus.load_configuration_i) begin
                        state_d     = CFG;
                        cfg_start_d = 1'b1;
                        done_cfg_d  = 1'b0;
                        cnt_cfg_d   = '0;
                    end else if (bus.start_execution_i) begin
                        state_d     = EXEC;
                        in_start_d  = bus.in_active_i;
                        out_start_d = bus.out_active_i;
                        pending_d   = bus.out_active_i;
                        done_exec_d = 1'b0;
                        cnt_exec_d  = '0;
                        cnt_stall_d = '0;
                    end
                end
            end
            CFG: begin
                cnt_cfg_d = sat_inc(cnt_cfg_q);
                if (bus.cfg_done_i) begin
                    state_d    = IDLE;
                    done_cfg_d = 1'b1;
                end
            end
            EXEC: begin
                cnt_exec_d = sat_inc(cnt_exec_q);
                if (bus.stall_i) cnt_stall_d = sat_inc(cnt_stall_q);
                pending_d = remaining;
                if (remaining == '0) begin
                    state_d     = IDLE;
                    done_exec_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The aborted cycle is still counted; only control state is discarded.
        if (bus.reset_state_machines_i) begin
            state_d     = IDLE;
            pending_d   = '0;
            cfg_start_d = 1'b0;
            in_start_d  = '0;
            out_start_d = '0;
            done_cfg_d  = 1'b0;
            done_exec_d = 1'b0;
        end
    end

    assign bus.cfg_start_o               = cfg_start_q;
    assign bus.in_start_o                = in_start_q;
    assign bus.out_start_o               = out_start_q;
    assign bus.clr_config_o              = clr_config_q;
    assign bus.clr_state_o               = clr_state_q;
    assign bus.done_config_o             = done_cfg_q;
    assign bus.done_exec_output_o        = done_exec_q;
    assign bus.busy_o                    = (state_q != IDLE);
    assign bus.cycle_count_load_config_o = cnt_cfg_q;
    assign bus.cycle_count_execute_o     = cnt_exec_q;
    assign bus.cycle_count_stall_o       = cnt_stall_q;
endmodule

// File: tb/tb_cgra_exec_sequencer.sv
// Scoreboard bench for cgra_exec_sequencer: directed vectors push expected events,
// a negedge monitor pops them on every output pulse and every busy->idle transition.
module tb_cgra_exec_sequencer;
    logic clk;
    logic rst_n;

    cgra_exec_sequencer_if #(.INPUT_NODES_NUM(4), .OUTPUT_NODES_NUM(4)) bus ();

    cgra_exec_sequencer #(.INPUT_NODES_NUM(4), .OUTPUT_NODES_NUM(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          is_pulse;
        logic [10:0] pulses;  // {cfg_start, in_start[3:0], out_start[3:0], clr_config, clr_state}
        logic [1:0]  flags;   // {done_config, done_exec_output}
        logic [31:0] ccfg;
        logic [31:0] cexec;
        logic [31:0] cstall;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic busy_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic exp_pulse(input string n, input logic [10:0] p);
        exp_t e;
        e.name = n; e.is_pulse = 1'b1; e.pulses = p; e.flags = '0;
        e.ccfg = '0; e.cexec = '0; e.cstall = '0;
        sb.push_back(e);
    endtask

    task automatic exp_done(input string n, input logic [1:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] c);
        exp_t e;
        e.name = n; e.is_pulse = 1'b0; e.pulses = '0; e.flags = f;
        e.ccfg = a; e.cexec = b; e.cstall = c;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        logic [10:0] p;
        exp_t        e;
        p = {bus.cfg_start_o, bus.in_start_o, bus.out_start_o, bus.clr_config_o, bus.clr_state_o};
        if (p != '0) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_pulse actual=%0h expected=none", p);
            end else begin
                e = sb.pop_front();
                check({e.name, "_kind"}, {63'd0, e.is_pulse}, 64'd1);
                check({e.name, "_pulses"}, {53'd0, p}, {53'd0, e.pulses});
            end
        end
        if (busy_prev && !bus.busy_o) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_completion actual=event expected=none");
            end else begin
                e = sb.pop_front();
                check({e.name, "_kind"}, {63'd0, e.is_pulse}, 64'd0);
                check({e.name, "_flags"}, {62'd0, bus.done_config_o, bus.done_exec_output_o},
                      {62'd0, e.flags});
                check({e.name, "_cnt_cfg"}, {32'd0, bus.cycle_count_load_config_o}, {32'd0, e.ccfg});
                check({e.name, "_cnt_exec"}, {32'd0, bus.cycle_count_execute_o}, {32'd0, e.cexec});
                check({e.name, "_cnt_stall"}, {32'd0, bus.cycle_count_stall_o}, {32'd0, e.cstall});
            end
        end
        busy_prev <= bus.busy_o;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.load_configuration_i   = 1'b0;
        bus.start_execution_i      = 1'b0;
        bus.clear_cgra_config_i    = 1'b0;
        bus.clear_cgra_state_i     = 1'b0;
        bus.reset_state_machines_i = 1'b0;
        bus.cfg_done_i             = 1'b0;
        bus.out_done_i             = '0;
        bus.stall_i                = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_outs"}, {50'd0, bus.cfg_start_o, bus.in_start_o, bus.out_start_o,
              bus.clr_config_o, bus.clr_state_o, bus.done_config_o, bus.done_exec_output_o,
              bus.busy_o}, 64'd0);
        check({name, "_cnt_cfg_exec"}, {bus.cycle_count_load_config_o, bus.cycle_count_execute_o}, 64'd0);
        check({name, "_cnt_stall"}, {32'd0, bus.cycle_count_stall_o}, 64'd0);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 20 && bus.busy_o; i++) step();
        check({name, "_idle"}, {63'd0, bus.busy_o}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        bus.in_active_i  = '0;
        bus.out_active_i = '0;

        // Reset, with a load command held during reset (must be discarded)
        step();
        bus.load_configuration_i = 1'b1;
        step();
        bus.load_configuration_i = 1'b0;
        rst_n = 1'b1;
        step();
        check_all_zero("reset");

        // Config load, cfg_done 5 cycles after cfg_start
        exp_pulse("cfg_pulse", {1'b1, 4'b0000, 4'b0000, 2'b00});
        exp_done("cfg_done", 2'b10, 32'd6, 32'd0, 32'd0);
        bus.load_configuration_i = 1'b1;
        step();
        bus.load_configuration_i = 1'b0;
        repeat (5) step();
        bus.cfg_done_i = 1'b1;
        step();
        bus.cfg_done_i = 1'b0;
        wait_idle("cfg");

        // Execute with two active outputs, stalls, done for an inactive node
        exp_pulse("exec_pulse", {1'b0, 4'b0011, 4'b0101, 2'b00});
        exp_done("exec_done", 2'b11, 32'd6, 32'd7, 32'd2);
        bus.in_active_i = 4'b0011;
        bus.out_active_i = 4'b0101;
        bus.start_execution_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            bus.start_execution_i = 1'b0;
            bus.in_active_i  = '0;
            bus.out_active_i = '0;
            bus.out_done_i = (k == 3) ? 4'b0001 : (k == 5) ? 4'b0010 : (k == 7) ? 4'b0100 : 4'b0000;
            bus.stall_i    = (k == 2 || k == 4);
        end
        clear_inputs();
        wait_idle("exec");

        // No active outputs: exactly one EXEC cycle
        exp_pulse("noout_pulse", {1'b0, 4'b1010, 4'b0000, 2'b00});
        exp_done("noout_done", 2'b11, 32'd6, 32'd1, 32'd1);
        bus.in_active_i = 4'b1010;
        bus.out_active_i = 4'b0000;
        bus.start_execution_i = 1'b1;
        bus.stall_i = 1'b1;
        step();
        clear_inputs();
        bus.stall_i = 1'b1;
        step();
        clear_inputs();
        wait_idle("noout");

        // Load and start together, then commands during CFG: only config runs
        exp_pulse("both_pulse", {1'b1, 4'b0000, 4'b0000, 2'b00});
        exp_done("both_done", 2'b11, 32'd3, 32'd1, 32'd1);
        bus.in_active_i = 4'b1111;
        bus.out_active_i = 4'b1111;
        bus.load_configuration_i = 1'b1;
        bus.start_execution_i = 1'b1;
        step();
        clear_inputs();
        step();
        bus.load_configuration_i = 1'b1;
        bus.start_execution_i = 1'b1;
        step();
        clear_inputs();
        bus.cfg_done_i = 1'b1;
        step();
        clear_inputs();
        wait_idle("both");

        // Abort in EXEC cycle 4 with a simultaneous start, then a normal run
        exp_pulse("abort_pulse", {1'b0, 4'b0001, 4'b1000, 2'b00});
        exp_done("abort_done", 2'b00, 32'd3, 32'd4, 32'd1);
        bus.in_active_i = 4'b0001;
        bus.out_active_i = 4'b1000;
        bus.start_execution_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            clear_inputs();
            bus.stall_i = (k == 2);
            if (k == 4) begin
                bus.reset_state_machines_i = 1'b1;
                bus.start_execution_i = 1'b1;
            end
        end
        clear_inputs();
        wait_idle("abort");
        step();
        exp_pulse("rerun_pulse", {1'b0, 4'b0100, 4'b0010, 2'b00});
        exp_done("rerun_done", 2'b01, 32'd3, 32'd2, 32'd0);
        bus.in_active_i = 4'b0100;
        bus.out_active_i = 4'b0010;
        bus.start_execution_i = 1'b1;
        step();
        clear_inputs();
        step();
        bus.out_done_i = 4'b0010;
        step();
        clear_inputs();
        wait_idle("rerun");

        // Clear pulses
        exp_pulse("clr_cfg", {1'b0, 4'b0000, 4'b0000, 2'b10});
        exp_pulse("clr_state", {1'b0, 4'b0000, 4'b0000, 2'b01});
        exp_pulse("clr_both", {1'b0, 4'b0000, 4'b0000, 2'b11});
        bus.clear_cgra_config_i = 1'b1;
        step();
        clear_inputs();
        step();
        bus.clear_cgra_state_i = 1'b1;
        step();
        clear_inputs();
        step();
        bus.clear_cgra_config_i = 1'b1;
        bus.clear_cgra_state_i = 1'b1;
        step();
        clear_inputs();
        repeat (2) step();

        // Execute counter saturation
        exp_pulse("sat_pulse", {1'b0, 4'b0000, 4'b0001, 2'b00});
        exp_done("sat_done", 2'b01, 32'd3, 32'hFFFF_FFFF, 32'd0);
        bus.in_active_i = 4'b0000;
        bus.out_active_i = 4'b0001;
        bus.start_execution_i = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            clear_inputs();
            if (k == 1) begin
                force dut.cnt_exec_q = 32'hFFFF_FFFE;
                #1 release dut.cnt_exec_q;
            end
            if (k == 6) bus.out_done_i = 4'b0001;
        end
        clear_inputs();
        wait_idle("sat");

        // rst_ni low mid-CFG, then a stray cfg_done in IDLE
        exp_pulse("rst_pulse", {1'b1, 4'b0000, 4'b0000, 2'b00});
        exp_done("rst_done", 2'b00, 32'd0, 32'd0, 32'd0);
        bus.load_configuration_i = 1'b1;
        step();
        clear_inputs();
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_all_zero("midcfg_reset");
        bus.cfg_done_i = 1'b1;
        step();
        clear_inputs();
        repeat (3) step();
        check("stray_cfg_done_busy", {63'd0, bus.busy_o}, 64'd0);
        check("stray_cfg_done_flag", {63'd0, bus.done_config_o}, 64'd0);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
